// File: rtl/router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : router_pkt_tx
//  Brief    : Source-side packet transmitter. Buffers a full payload from the
//             client, then emits header, payload and parity as one contiguous
//             burst toward the router input, stalling on router busy.
//  Revision : 1.0  initial release
// ============================================================================
module router_pkt_tx #(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 6,
    parameter int ADDR_W   = 2,
    parameter int BAD_ADDR = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  pay_len,
    input  logic              corrupt_par,
    input  logic [DATA_W-1:0] pl_data,
    input  logic              pl_valid,
    output logic              pl_ready,
    input  logic              busy,
    output logic              pkt_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              tx_idle,
    output logic              done,
    output logic              cmd_err
);

    localparam int c_DEPTH = 2 ** LEN_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_dest;
    logic [LEN_W-1:0]  r_len;
    logic              r_corrupt;
    logic [DATA_W-1:0] r_parity;
    logic [LEN_W-1:0]  r_wr_idx;
    logic [LEN_W-1:0]  r_rd_idx;
    logic [DATA_W-1:0] r_buf [0:c_DEPTH-1];
    logic [DATA_W-1:0] r_data_out;
    logic              r_pkt_valid;
    logic              r_done;
    logic              r_cmd_err;

    logic              w_cmd_ok;
    logic              w_load_wr;
    logic              w_load_last;
    logic              w_last_rd;
    logic [DATA_W-1:0] w_header;
    logic [DATA_W-1:0] w_cmd_header;

    // A command is legal only with a non-zero length and a routable address
    assign w_cmd_ok     = (pay_len != '0) && (dest_addr != ADDR_W'(BAD_ADDR));
    assign w_load_wr    = (r_state == S_LOAD) && pl_valid;
    assign w_load_last  = w_load_wr && (r_wr_idx == (r_len - 1'b1));
    // rd_idx points one past the byte currently presented on data_out
    assign w_last_rd    = (r_rd_idx == r_len);
    assign w_header     = DATA_W'({r_len, r_dest});
    assign w_cmd_header = DATA_W'({pay_len, dest_addr});

    assign pl_ready  = (r_state == S_LOAD);
    assign tx_idle   = (r_state == S_IDLE);
    assign pkt_valid = r_pkt_valid;
    assign data_out  = r_data_out;
    assign done      = r_done;
    assign cmd_err   = r_cmd_err;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state selection; busy only matters once the burst has started
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start && w_cmd_ok)    w_state_nxt = S_LOAD;
            S_LOAD:    if (w_load_last)          w_state_nxt = S_HEADER;
            S_HEADER:  if (!busy)                w_state_nxt = S_PAYLOAD;
            S_PAYLOAD: if (!busy && w_last_rd)   w_state_nxt = S_PARITY;
            S_PARITY:  if (!busy)                w_state_nxt = S_IDLE;
            default:                             w_state_nxt = S_IDLE;
        endcase
    end

    // Payload buffer write port; contents need no reset
    always_ff @(posedge clock) begin
        if (w_load_wr) r_buf[r_wr_idx] <= pl_data;
    end

    // Command latch, parity accumulation and registered packet outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dest      <= '0;
            r_len       <= '0;
            r_corrupt   <= 1'b0;
            r_parity    <= '0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_data_out  <= '0;
            r_pkt_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cmd_ok) begin
                            r_dest    <= dest_addr;
                            r_len     <= pay_len;
                            r_corrupt <= corrupt_par;
                            r_parity  <= w_cmd_header;
                            r_wr_idx  <= '0;
                            r_rd_idx  <= '0;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (pl_valid) begin
                        r_parity <= r_parity ^ pl_data;
                        r_wr_idx <= r_wr_idx + 1'b1;
                        if (w_load_last) begin
                            r_data_out  <= w_header;
                            r_pkt_valid <= 1'b1;
                        end
                    end
                end
                S_HEADER, S_PAYLOAD: begin
                    if (!busy) begin
                        if ((r_state == S_PAYLOAD) && w_last_rd) begin
                            r_data_out  <= r_corrupt ? ~r_parity : r_parity;
                            r_pkt_valid <= 1'b0;
                        end else begin
                            r_data_out <= r_buf[r_rd_idx];
                            r_rd_idx   <= r_rd_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        r_data_out <= '0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_pkt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_router_pkt_tx
//  Brief    : Self-checking bench for router_pkt_tx with a queue-based
//             packet reference model and randomized payload/gaps/stalls.
//  Revision : 1.0  initial release
// ============================================================================
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pay_len;
    logic       corrupt_par;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_idle;
    logic       done;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    router_pkt_tx #(
        .DATA_W   (8),
        .LEN_W    (6),
        .ADDR_W   (2),
        .BAD_ADDR (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dest_addr   (dest_addr),
        .pay_len     (pay_len),
        .corrupt_par (corrupt_par),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .busy        (busy),
        .pkt_valid   (pkt_valid),
        .data_out    (data_out),
        .tx_idle     (tx_idle),
        .done        (done),
        .cmd_err     (cmd_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle-state output check (after reset or a rejected command)
    task automatic chk_idle(input string tag);
        chk({tag, "_pv"},    32'(pkt_valid), 0);
        chk({tag, "_data"},  32'(data_out),  0);
        chk({tag, "_ready"}, 32'(pl_ready),  0);
        chk({tag, "_idle"},  32'(tx_idle),   1);
        chk({tag, "_done"},  32'(done),      0);
    endtask

    // One packet: command, client load, burst out.
    // fixed: payload 1..L; stall_pat: busy 3 cycles on header and payload byte 4.
    // abort_idx >= 0 pulses reset when that burst byte is presented.
    task automatic tx_pkt(input int addr, input int len, input bit corrupt,
                          input int gap_pct, input int busy_pct,
                          input bit fixed, input bit stall_pat, input int abort_idx);
        logic [7:0] pay[$];
        logic [7:0] exp_q[$];
        logic [7:0] hdr;
        logic [7:0] par;
        int k;
        int idx;
        int hold;
        int cyc;
        pay = {};
        for (int i = 0; i < len; i++)
            pay.push_back(fixed ? 8'(i + 1) : 8'($urandom));
        hdr = {6'(len), 2'(addr)};
        par = hdr;
        foreach (pay[i]) par = par ^ pay[i];
        if (corrupt) par = ~par;
        exp_q = {hdr};
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(par);

        @(negedge clock);
        start = 1'b1; dest_addr = 2'(addr); pay_len = 6'(len); corrupt_par = corrupt;
        pl_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        chk("accept_idle", 32'(tx_idle), 0);

        k = 0;
        while (k < len) begin
            chk("load_ready", 32'(pl_ready), 1);
            chk("load_pv", 32'(pkt_valid), 0);
            pl_valid = ($urandom_range(99) >= gap_pct);
            pl_data = pay[k];
            busy = 1'($urandom_range(1));
            // command-port noise: must be ignored outside IDLE
            start = 1'($urandom_range(1));
            dest_addr = 2'($urandom);
            pay_len = 6'($urandom_range(63, 1));
            corrupt_par = 1'($urandom_range(1));
            if (pl_valid) k++;
            @(negedge clock);
        end
        pl_valid = 1'b0;
        start = 1'b0;

        idx = 0; hold = 0; cyc = 0;
        while (idx < len + 2) begin
            if (abort_idx >= 0 && idx == abort_idx) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                chk_idle("abort");
                return;
            end
            chk("burst_byte", 32'(data_out), 32'(exp_q[idx]));
            chk("burst_pv", 32'(pkt_valid), (idx <= len) ? 1 : 0);
            chk("burst_ready", 32'(pl_ready), 0);
            chk("burst_idle", 32'(tx_idle), 0);
            chk("burst_done", 32'(done), 0);
            if (stall_pat)
                busy = (idx == 0 || idx == 4) && hold < 3;
            else
                busy = (cyc < 2 * (len + 2)) && ($urandom_range(99) < busy_pct);
            if (busy) hold++;
            else begin idx++; hold = 0; end
            cyc++;
            @(negedge clock);
        end
        busy = 1'b0;
        chk("end_done", 32'(done), 1);
        chk("end_idle", 32'(tx_idle), 1);
        chk("end_pv", 32'(pkt_valid), 0);
        chk("end_data", 32'(data_out), 0);
        @(negedge clock);
        chk("done_pulse", 32'(done), 0);
    endtask

    // Rejected command: cmd_err pulses once, nothing else moves
    task automatic bad_cmd(input int addr, input int len);
        @(negedge clock);
        start = 1'b1; dest_addr = 2'(addr); pay_len = 6'(len); corrupt_par = 1'b0;
        busy = 1'($urandom_range(1));
        @(negedge clock);
        start = 1'b0;
        chk("bad_err", 32'(cmd_err), 1);
        chk_idle("bad");
        @(negedge clock);
        chk("bad_err_pulse", 32'(cmd_err), 0);
        chk_idle("bad_after");
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dest_addr = '0; pay_len = '0; corrupt_par = 1'b0;
        pl_data = '0; pl_valid = 1'b0; busy = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk_idle("reset");
        chk("reset_err", 32'(cmd_err), 0);

        // T1 basic packet
        tx_pkt(2, 8, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        // T2 stalls on header and payload byte 04
        tx_pkt(2, 8, 1'b0, 0, 0, 1'b1, 1'b1, -1);
        // T3 corrupted parity
        tx_pkt(2, 14, 1'b1, 20, 30, 1'b0, 1'b0, -1);
        // T4 illegal commands
        bad_cmd(1, 0);
        bad_cmd(3, 5);
        bad_cmd(3, 0);
        // T5 maximum length with gapped loading
        tx_pkt(1, 63, 1'b0, 40, 20, 1'b0, 1'b0, -1);
        // minimum length
        tx_pkt(0, 1, 1'b0, 30, 40, 1'b0, 1'b0, -1);
        tx_pkt(2, 1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
        // T6 reset on payload byte 5, then a clean T1 packet
        tx_pkt(2, 8, 1'b0, 0, 30, 1'b1, 1'b0, 5);
        tx_pkt(2, 8, 1'b0, 0, 0, 1'b1, 1'b0, -1);
        // randomized packets
        for (int n = 0; n < 8; n++)
            tx_pkt(int'($urandom_range(2)), int'($urandom_range(63, 1)),
                   1'($urandom_range(1)), 30, 30, 1'b0, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
